// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronises and debounces encoder channels A/B and
// emits a one-cycle count enable plus direction for an up/down counter.
module quadrature_decoder #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_a,
    input  logic       in_b,
    input  logic [1:0] mode,
    input  logic       err_clr,
    output logic       ena,
    output logic       updown,
    output logic       err,
    output logic       err_flag
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
    localparam logic [1:0] INIT_DONE = 2'd3;

    // Channel vectors are ordered {A, B}
    logic [1:0]            s1;
    logic [1:0]            s2;
    logic [1:0]            filt;
    logic [1:0][CNT_W-1:0] cnt;
    logic [1:0]            prev;
    logic [1:0]            t_old;
    logic [1:0]            t_new;
    logic [1:0]            init_cnt;
    logic                  init_busy_c;

    logic [1:0]            chg_c;
    logic                  illegal_c;
    logic                  legal_c;
    logic                  dir_up_c;
    logic                  count_c;

    // Gray position along the up sequence 00 -> 10 -> 11 -> 01
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            2'b00:   pos = 2'd0;
            2'b10:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    assign init_busy_c = (init_cnt != INIT_DONE);

    // Three-clock init window after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt <= '0;
        end else if (init_busy_c) begin
            init_cnt <= init_cnt + 2'd1;
        end
    end

    // Two-flop synchronisers for both channels
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {in_a, in_b};
            s2 <= s1;
        end
    end

    // Per-channel persistence filter; init loads the synchronised level directly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt <= '0;
            cnt  <= '0;
        end else if (init_busy_c) begin
            filt <= s2;
            cnt  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Previous filtered position and the registered transition pair fed to decode
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev  <= '0;
            t_old <= '0;
            t_new <= '0;
        end else if (init_busy_c) begin
            prev  <= s2;
            t_old <= s2;
            t_new <= s2;
        end else begin
            prev  <= filt;
            t_old <= prev;
            t_new <= filt;
        end
    end

    // Transition classification and mode-dependent count qualification
    always_comb begin
        chg_c     = t_old ^ t_new;
        illegal_c = (chg_c == 2'b11);
        legal_c   = (chg_c == 2'b01) || (chg_c == 2'b10);
        dir_up_c  = (gray_pos(t_new) == (gray_pos(t_old) + 2'd1));
        count_c   = 1'b0;
        case (mode)
            2'b00:   count_c = ((t_old == 2'b00) && (t_new == 2'b10)) ||
                               ((t_old == 2'b10) && (t_new == 2'b00));
            2'b01:   count_c = legal_c && (t_old[1] != t_new[1]);
            default: count_c = legal_c;
        endcase
    end

    // Registered outputs; an error set outranks a simultaneous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ena      <= 1'b0;
            err      <= 1'b0;
            err_flag <= 1'b0;
            updown   <= 1'b1;
        end else if (init_busy_c) begin
            ena <= 1'b0;
            err <= 1'b0;
            if (err_clr) begin
                err_flag <= 1'b0;
            end
        end else begin
            ena <= count_c;
            err <= illegal_c;
            if (count_c) begin
                updown <= dir_up_c;
            end
            if (illegal_c) begin
                err_flag <= 1'b1;
            end else if (err_clr) begin
                err_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quadrature_decoder.sv
module tb_quadrature_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_a = 1'b0;
    logic       in_b = 1'b0;
    logic [1:0] mode = 2'b10;
    logic       err_clr = 1'b0;
    logic       ena;
    logic       updown;
    logic       err;
    logic       err_flag;

    int checks = 0;
    int errors = 0;
    int n_ena, n_up, n_dn, n_err;
    int ctr = 0;
    int n_ovf = 0;
    int idx;
    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    quadrature_decoder #(.FILTER_LEN(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_a     (in_a),
        .in_b     (in_b),
        .mode     (mode),
        .err_clr  (err_clr),
        .ena      (ena),
        .updown   (updown),
        .err      (err),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; sample just after the edge and fold pulses into the tallies
    task automatic tick();
        @(posedge clk);
        #1;
        if (ena) begin
            n_ena++;
            if (updown) begin
                n_up++;
                if (ctr == 255) begin
                    ctr = 0;
                    n_ovf++;
                end else begin
                    ctr++;
                end
            end else begin
                n_dn++;
                ctr = (ctr == 0) ? 255 : ctr - 1;
            end
        end
        if (err) n_err++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic clr_counts();
        n_ena = 0;
        n_up  = 0;
        n_dn  = 0;
        n_err = 0;
    endtask

    task automatic set_ab(input logic [1:0] ab);
        in_a = ab[1];
        in_b = ab[0];
    endtask

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : main
        clr_counts();
        run(3);
        chk("rst_ena", ena, 0);
        chk("rst_err", err, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_updown", updown, 1);
        rst = 1'b1;
        run(10);
        chk("init_ena", n_ena, 0);
        chk("init_err", n_err, 0);

        // x4 up with latency check
        mode = 2'b10;
        clr_counts();
        set_ab(2'b10);
        run(7);
        chk("lat_pre", ena, 0);
        run(1);
        chk("lat_edge7", ena, 1);
        run(1);
        chk("lat_edge8", ena, 0);
        run(1);
        set_ab(2'b11); run(10);
        set_ab(2'b01); run(10);
        set_ab(2'b00); run(10);
        chk("x4_ena", n_ena, 4);
        chk("x4_up", n_up, 4);
        chk("x4_updown", updown, 1);
        chk("x4_err", n_err, 0);

        // x2 down, two full cycles
        mode = 2'b01;
        clr_counts();
        repeat (2) begin
            set_ab(2'b01); run(10);
            set_ab(2'b11); run(10);
            set_ab(2'b10); run(10);
            set_ab(2'b00); run(10);
        end
        chk("x2_ena", n_ena, 4);
        chk("x2_dn", n_dn, 4);
        chk("x2_updown", updown, 0);
        chk("x2_err", n_err, 0);

        // x1 down, two full cycles
        mode = 2'b00;
        clr_counts();
        repeat (2) begin
            set_ab(2'b01); run(10);
            set_ab(2'b11); run(10);
            set_ab(2'b10); run(10);
            set_ab(2'b00); run(10);
        end
        chk("x1_ena", n_ena, 2);
        chk("x1_dn", n_dn, 2);
        chk("x1_updown", updown, 0);
        chk("x1_err", n_err, 0);

        // Glitch shorter than FILTER_LEN
        mode = 2'b10;
        clr_counts();
        set_ab(2'b10); run(3);
        set_ab(2'b00); run(12);
        chk("glitch_filt", dut.filt[1], 0);
        chk("glitch_ena", n_ena, 0);
        chk("glitch_err", n_err, 0);

        // Illegal two-bit step
        clr_counts();
        set_ab(2'b11); run(12);
        chk("ill_err", n_err, 1);
        chk("ill_flag", err_flag, 1);
        chk("ill_ena", n_ena, 0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        run(1);
        chk("ill_clr", err_flag, 0);
        clr_counts();
        set_ab(2'b00); run(7);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("ill_both_err", err, 1);
        run(4);
        chk("ill_both_flag", err_flag, 1);
        chk("ill_both_cnt", n_err, 1);
        chk("ill_both_ena", n_ena, 0);

        // Reset with inputs at 11
        rst = 1'b0;
        set_ab(2'b11);
        run(3);
        chk("rst2_flag", err_flag, 0);
        clr_counts();
        rst = 1'b1;
        run(20);
        chk("rst11_ena", n_ena, 0);
        chk("rst11_err", n_err, 0);
        set_ab(2'b01); run(10);
        chk("rst11_step_ena", n_ena, 1);
        chk("rst11_step_up", n_up, 1);
        chk("rst11_updown", updown, 1);

        // Counter hookup: 300 up, 44 down
        clr_counts();
        ctr = 0;
        n_ovf = 0;
        idx = 3;
        repeat (300) begin
            idx = (idx + 1) % 4;
            set_ab(gray[idx]);
            run(10);
        end
        repeat (44) begin
            idx = (idx + 3) % 4;
            set_ab(gray[idx]);
            run(10);
        end
        chk("ctr_up", n_up, 300);
        chk("ctr_dn", n_dn, 44);
        chk("ctr_val", ctr, 0);
        chk("ctr_ovf", n_ovf, 1);
        chk("ctr_err", n_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Upstream stage of the up/down binary counter: converts raw encoder channels A/B into a one-cycle count enable plus a direction level.

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, meaning the number of consecutive clocks a synchronised channel must differ from its filtered value before the filtered value updates (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_a, input, 1 bit: raw encoder channel A, asynchronous to clk.
REQ-005 SHALL have port in_b, input, 1 bit: raw encoder channel B, asynchronous to clk.
REQ-006 SHALL have port mode, input, 2 bits: decoding resolution, where 00 = x1, 01 = x2, and 10 or 11 = x4.
REQ-007 SHALL have port err_clr, input, 1 bit: synchronous clear of err_flag.
REQ-008 SHALL have port ena, output, 1 bit: one-cycle count-enable pulse, wired directly to the counter's ena.
REQ-009 SHALL have port updown, output, 1 bit: direction, where 1 = count up and 0 = count down; wired to the counter's updown.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse on an illegal transition.
REQ-011 SHALL have port err_flag, output, 1 bit: sticky illegal-transition indicator.

Function
REQ-012 SHALL pass each of in_a and in_b through an independent 2-flop synchroniser (s2_a, s2_b).
REQ-013 SHALL filter each channel independently: if s2 == filt, cnt <= 0; else if cnt == FILTER_LEN-1, filt <= s2 and cnt <= 0; else cnt <= cnt+1.
REQ-014 SHALL register prev <= {filt_a, filt_b} every clock; decode SHALL compare cur = {filt_a, filt_b} against prev.
REQ-015 SHALL treat 00->10->11->01->00 (bit order {A,B}) as up and the reverse sequence as down.
REQ-016 SHALL, in x4 mode, count every legal single-bit transition.
REQ-017 SHALL, in x2 mode, count only transitions in which A changes: 00->10 and 11->01 up; 10->00 and 01->11 down.
REQ-018 SHALL, in x1 mode, count only 00->10 as up and 10->00 as down.
REQ-019 SHALL register ena high for exactly one clock per counted transition, and SHALL register updown to that transition's direction in the same clock.
REQ-020 SHALL hold updown at its last value when no transition is counted.
REQ-021 SHALL, when cur == prev, keep ena = 0 and err = 0.
REQ-022 SHALL treat a two-bit change (00<->11 or 10<->01) as illegal: ena = 0, err pulses for 1 clock, err_flag <= 1, updown held.
REQ-023 SHALL clear err_flag on err_clr; if err and err_clr occur in the same clock, the set SHALL win.
REQ-024 SHALL apply a mode change on the next evaluated transition; a mode change SHALL not itself produce ena or err.
REQ-025 SHALL give a latency, for a clean raw edge stable from before edge 0, of ena high in the cycle after edge 3+FILTER_LEN (FILTER_LEN=4: ena asserts at edge 7, deasserts at edge 8).
REQ-026 SHALL reject glitches: a raw pulse shorter than FILTER_LEN clocks (after sync) SHALL never change filt, and SHALL produce no ena and no err.
REQ-027 SHALL never assert ena and err in the same cycle.

Reset
REQ-028 SHALL, with rst low, asynchronously set the sync flops, filt, prev and all filter counters to 0, and set ena = 0, err = 0, err_flag = 0 and updown = 1.
REQ-029 SHALL, after rst rises, run a 3-clock init phase with filt <= s2 and prev <= {s2_a, s2_b} unconditionally and ena/err forced 0, so that the initial encoder position is never counted or flagged.
REQ-030 SHALL, on rst asserted mid-operation, immediately clear any in-flight ena/err pulse and filter progress; init then SHALL repeat on release.

Verification
REQ-031 SHALL cover x4 up: FILTER_LEN=4, A/B stepped 00->10->11->01->00 with 10 clocks per step -> 4 ena pulses, updown = 1 throughout, first ena at edge 7 after the A change.
REQ-032 SHALL cover x1/x2 down: the reverse sequence, 2 full cycles -> x2 gives 4 ena pulses, x1 gives 2, updown = 0, err = 0.
REQ-033 SHALL cover the glitch: A high for 3 clocks with FILTER_LEN=4 -> filt_a unchanged, no ena, no err.
REQ-034 SHALL cover an illegal step: A and B both rise within the same clock from 00 -> err one pulse, err_flag = 1, no ena; err_clr pulse -> err_flag = 0; err and err_clr together -> err_flag = 1.
REQ-035 SHALL cover reset with inputs at 11: release rst -> no ena and no err during or after init; a subsequent 11->01 step -> one ena with updown = 1.
REQ-036 SHALL cover the counter hookup: outputs driving an 8-bit binary up/down counter, 300 x4 up steps then 44 down -> counter = 0x00 (256+44-44 wrap), ovf pulsed once on the 255->0 wrap.
